sar_adc8_wb_wrapper: RTL and testbench

Wishbone-slave controller for an 8-bit successive-approximation ADC. It is the capture-side counterpart of the DAC wrapper on the same peripheral bus. It sequences a sample/hold switch, drives trial codes into the SAR capacitive DAC and resolves one bit per step from an external analog comparator. Results and status are exposed to the management SoC through memory-mapped registers.

---
 rtl/sar_adc8_wb_wrapper_pkg.sv | 14 +
 rtl/sar_adc8_wb_wrapper_sar_ctrl.sv | 92 +++++++++
 rtl/sar_adc8_wb_wrapper.sv | 78 +++++++
 tb/tb_sar_adc8_wb_wrapper.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sar_adc8_wb_wrapper_pkg.sv
// sar_adc8_wb_wrapper_pkg: register map, bit indices and FSM encoding shared by the SAR ADC wrapper
package sar_adc8_wb_wrapper_pkg;
    localparam logic [7:0]  ADR_DATA   = 8'h00;
    localparam logic [7:0]  ADR_CTRL   = 8'h04;
    localparam logic [7:0]  ADR_STATUS = 8'h08;
    localparam logic [7:0]  ADR_CLKDIV = 8'h0C;
    localparam logic [31:0] RD_DEFAULT = 32'hDEAD_BEEF;
    localparam int CTRL_EN    = 0;
    localparam int CTRL_START = 1;
    localparam int CTRL_CONT  = 2;
    localparam int STAT_BUSY  = 0;
    localparam int STAT_DONE  = 1;
    typedef enum logic [1:0] {ST_IDLE, ST_SAMPLE, ST_CONVERT, ST_DONE} state_e;
endpackage

// File: rtl/sar_adc8_wb_wrapper_sar_ctrl.sv
// sar_adc8_wb_wrapper_sar_ctrl: sample/convert sequencer with comparator synchronizer and trial register
// Ports: clk_i/rst_i clock and async reset; en_i/start_i/cont_i/clkdiv_i control;
// cmp_i raw comparator; sh_en_o/dac_o analog drive; busy_o, done_o (result valid pulse), result_o.
module sar_adc8_wb_wrapper_sar_ctrl
    import sar_adc8_wb_wrapper_pkg::*;
#(
    parameter int SAMPLE_CYCLES = 4
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       en_i,
    input  logic       start_i,
    input  logic       cont_i,
    input  logic [7:0] clkdiv_i,
    input  logic       cmp_i,
    output logic       sh_en_o,
    output logic [7:0] dac_o,
    output logic       busy_o,
    output logic       done_o,
    output logic [7:0] result_o
);
    localparam int SW = $clog2(SAMPLE_CYCLES + 1);
    state_e        state_q, state_d;
    logic [SW-1:0] samp_q, samp_d;
    logic [8:0]    step_q, step_d;
    logic [7:0]    div_q, div_d, trial_q, trial_d;
    logic [2:0]    bit_q, bit_d;
    logic [1:0]    sync_q;
    logic          cmp_s, step_end;
    assign cmp_s = sync_q[1];
    // 9-bit compare so CLKDIV=0xFF yields 258-cycle steps without wrapping
    assign step_end = step_q == {1'b0, div_q} + 9'd2;
    always_comb begin
        state_d = state_q;
        samp_d  = samp_q;
        step_d  = step_q;
        div_d   = div_q;
        bit_d   = bit_q;
        trial_d = trial_q;
        if (!en_i && state_q != ST_IDLE) state_d = ST_IDLE;
        else case (state_q)
            ST_IDLE: if (start_i) begin
                state_d = ST_SAMPLE;
                samp_d  = '0;
            end
            ST_SAMPLE: if (samp_q == SW'(SAMPLE_CYCLES - 1)) begin
                state_d = ST_CONVERT;
                bit_d   = 3'd7;
                trial_d = 8'h80;
                step_d  = '0;
                div_d   = clkdiv_i;
            end else samp_d = samp_q + 1'b1;
            ST_CONVERT: if (step_end) begin
                step_d = '0;
                // divider is re-latched per step so a CLKDIV write lands on a step boundary
                div_d  = clkdiv_i;
                if (!cmp_s) trial_d[bit_q] = 1'b0;
                if (bit_q != 3'd0) begin
                    trial_d[bit_q - 3'd1] = 1'b1;
                    bit_d = bit_q - 3'd1;
                end else state_d = ST_DONE;
            end else step_d = step_q + 9'd1;
            ST_DONE: begin
                state_d = cont_i ? ST_SAMPLE : ST_IDLE;
                samp_d  = '0;
            end
        endcase
    end
    always_ff @(posedge clk_i or posedge rst_i)
        if (rst_i) begin
            state_q <= ST_IDLE;
            samp_q  <= '0;
            step_q  <= '0;
            div_q   <= '0;
            bit_q   <= '0;
            trial_q <= '0;
            sync_q  <= '0;
        end else begin
            state_q <= state_d;
            samp_q  <= samp_d;
            step_q  <= step_d;
            div_q   <= div_d;
            bit_q   <= bit_d;
            trial_q <= trial_d;
            sync_q  <= {sync_q[0], cmp_i};
        end
    assign sh_en_o  = state_q == ST_SAMPLE;
    assign dac_o    = state_q == ST_IDLE ? 8'h00 : state_q == ST_SAMPLE ? 8'h80 : trial_q;
    assign busy_o   = state_q != ST_IDLE;
    assign done_o   = state_q == ST_DONE && en_i;
    assign result_o = trial_q;
endmodule

// File: rtl/sar_adc8_wb_wrapper.sv
// sar_adc8_wb_wrapper: Wishbone slave register file and bus front-end for the 8-bit SAR ADC
// Ports: sys_clk/sys_rst clock and async reset; bus_* Wishbone slave (ack registered, read combinational);
// cmp_in raw comparator; sh_en sample/hold switch; dac_data SAR DAC trial code; adc_ena analog bias enable.
module sar_adc8_wb_wrapper
    import sar_adc8_wb_wrapper_pkg::*;
#(
    parameter int SAMPLE_CYCLES = 4
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic [13:0] bus_adr,
    input  logic [31:0] bus_dat_w,
    output logic [31:0] bus_dat_r,
    input  logic [3:0]  bus_sel,
    input  logic        bus_cyc,
    input  logic        bus_stb,
    input  logic        bus_we,
    output logic        bus_ack,
    input  logic        cmp_in,
    output logic        sh_en,
    output logic [7:0]  dac_data,
    output logic        adc_ena
);
    logic       ack_q, ack_d, en_q, en_d, cont_q, cont_d, done_q, done_d;
    logic [7:0] data_q, data_d, clkdiv_q, clkdiv_d, adr, result;
    logic       wr, wr_ctrl, start, busy, conv_done;
    logic       unused;
    assign unused  = ^{bus_adr[13:8], bus_sel, bus_dat_w[31:8]};
    assign adr     = bus_adr[7:0];
    assign wr      = bus_cyc & bus_stb & bus_we & ~ack_q;
    assign wr_ctrl = wr && adr == ADR_CTRL;
    assign start   = wr_ctrl & bus_dat_w[CTRL_START] & bus_dat_w[CTRL_EN];
    always_comb begin
        ack_d     = bus_cyc & bus_stb & ~ack_q;
        en_d      = wr_ctrl ? bus_dat_w[CTRL_EN] : en_q;
        cont_d    = wr_ctrl ? bus_dat_w[CTRL_CONT] : cont_q;
        clkdiv_d  = wr && adr == ADR_CLKDIV ? bus_dat_w[7:0] : clkdiv_q;
        data_d    = conv_done ? result : data_q;
        // a completion in the same cycle as a W1C keeps DONE set
        done_d    = conv_done | (done_q & ~(wr && adr == ADR_STATUS && bus_dat_w[STAT_DONE]));
        bus_dat_r = adr == ADR_DATA   ? {24'h0, data_q} :
                    adr == ADR_CTRL   ? {29'h0, cont_q, 1'b0, en_q} :
                    adr == ADR_STATUS ? {30'h0, done_q, busy} :
                    adr == ADR_CLKDIV ? {24'h0, clkdiv_q} : RD_DEFAULT;
    end
    always_ff @(posedge sys_clk or posedge sys_rst)
        if (sys_rst) begin
            ack_q    <= 1'b0;
            en_q     <= 1'b0;
            cont_q   <= 1'b0;
            done_q   <= 1'b0;
            data_q   <= '0;
            clkdiv_q <= '0;
        end else begin
            ack_q    <= ack_d;
            en_q     <= en_d;
            cont_q   <= cont_d;
            done_q   <= done_d;
            data_q   <= data_d;
            clkdiv_q <= clkdiv_d;
        end
    assign bus_ack = ack_q;
    assign adc_ena = en_q;
    sar_adc8_wb_wrapper_sar_ctrl #(.SAMPLE_CYCLES(SAMPLE_CYCLES)) u_sar_ctrl (
        .clk_i    (sys_clk),
        .rst_i    (sys_rst),
        .en_i     (en_q),
        .start_i  (start),
        .cont_i   (cont_q),
        .clkdiv_i (clkdiv_q),
        .cmp_i    (cmp_in),
        .sh_en_o  (sh_en),
        .dac_o    (dac_data),
        .busy_o   (busy),
        .done_o   (conv_done),
        .result_o (result)
    );
endmodule

// File: tb/tb_sar_adc8_wb_wrapper.sv
// tb_sar_adc8_wb_wrapper: directed and randomized checks of the SAR ADC wrapper against an ideal-converter model
module tb_sar_adc8_wb_wrapper;
    localparam int SAMPLE = 4;
    logic        clk = 1'b0, rst = 1'b1;
    logic [13:0] adr = '0;
    logic [31:0] dat_w = '0, dat_r;
    logic [3:0]  sel = 4'hF;
    logic        cyc = 1'b0, stb = 1'b0, we = 1'b0, ack;
    logic        sh_en, adc_ena, cmp;
    logic [7:0]  dac, vin = 8'h00;
    int          n_chk = 0, n_fail = 0, cyc_n = 0, t_commit = 0;
    logic [7:0]  tr_dac[$];
    logic        tr_sh[$];

    assign cmp = vin >= dac;
    always #5 clk = ~clk;
    always @(posedge clk) cyc_n <= cyc_n + 1;

    sar_adc8_wb_wrapper #(.SAMPLE_CYCLES(SAMPLE)) dut (
        .sys_clk(clk), .sys_rst(rst), .bus_adr(adr), .bus_dat_w(dat_w), .bus_dat_r(dat_r),
        .bus_sel(sel), .bus_cyc(cyc), .bus_stb(stb), .bus_we(we), .bus_ack(ack),
        .cmp_in(cmp), .sh_en(sh_en), .dac_data(dac), .adc_ena(adc_ena)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wb_write(input logic [7:0] a, input logic [31:0] d);
        bit got = 0;
        @(negedge clk);
        adr = 14'(a); dat_w = d; cyc = 1; stb = 1; we = 1;
        for (int i = 0; i < 4 && !got; i++) begin
            @(posedge clk); #1;
            if (ack) begin got = 1; t_commit = cyc_n; end
        end
        chk("wr_ack", 32'(got), 1);
        @(negedge clk);
        cyc = 0; stb = 0; we = 0;
    endtask

    task automatic wb_read(input logic [7:0] a, output logic [31:0] d);
        bit got = 0;
        d = '0;
        @(negedge clk);
        adr = 14'(a); cyc = 1; stb = 1; we = 0;
        for (int i = 0; i < 4 && !got; i++) begin
            @(posedge clk); #1;
            if (ack) begin got = 1; d = dat_r; end
        end
        chk("rd_ack", 32'(got), 1);
        @(negedge clk);
        cyc = 0; stb = 0;
    endtask

    // Polls STATUS every cycle, recording dac_data/sh_en; entry j is the j-th cycle after t0.
    task automatic wait_done(input int t0, output int lat, output logic busy_first, output logic busy_end);
        bit got = 0;
        tr_dac.delete(); tr_sh.delete();
        adr = 14'h8; we = 0; cyc = 1; stb = 1;
        #1;
        busy_first = dat_r[0];
        for (int i = 0; i < 3000; i++) begin
            tr_dac.push_back(dac);
            tr_sh.push_back(sh_en);
            if (dat_r[1]) begin got = 1; break; end
            @(posedge clk); #1;
        end
        lat = cyc_n - t0;
        busy_end = dat_r[0];
        chk("done_seen", 32'(got), 1);
        cyc = 0; stb = 0;
    endtask

    // Ideal SAR: step i presents the already-resolved upper bits of vin plus the bit under test.
    function automatic logic [7:0] exp_dac(input logic [7:0] v, input int s, input int j);
        int vv, k, i;
        vv = v;
        if (j < SAMPLE) return 8'h80;
        k = j - SAMPLE;
        if (k < 8 * s) begin
            i = k / s;
            return 8'(((vv >> (8 - i)) << (8 - i)) | (128 >> i));
        end
        if (k == 8 * s) return v;
        return 8'h00;
    endfunction

    task automatic run_conv(input logic [7:0] v, input logic [7:0] div, input string tag);
        int lat, bad, s;
        logic bf, be;
        logic [31:0] d;
        vin = v;
        s = int'(div) + 3;
        wb_write(8'h0C, {24'h0, div});
        wb_write(8'h08, 32'h2);
        wb_write(8'h04, 32'h3);
        wait_done(t_commit, lat, bf, be);
        chk({tag, "_latency"}, lat, SAMPLE + 8 * s + 1);
        chk({tag, "_busy_start"}, 32'(bf), 1);
        chk({tag, "_busy_end"}, 32'(be), 0);
        bad = 0;
        for (int j = 0; j < tr_dac.size(); j++)
            if (tr_dac[j] !== exp_dac(v, s, j) || tr_sh[j] !== (j < SAMPLE)) bad++;
        chk({tag, "_trace_errors"}, bad, 0);
        wb_read(8'h00, d);
        chk({tag, "_data"}, d, {24'h0, v});
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] d;
        int lat, t1;
        logic bf, be;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_sh_en", 32'(sh_en), 0);
        chk("rst_dac", 32'(dac), 0);
        chk("rst_adc_ena", 32'(adc_ena), 0);
        chk("rst_ack", 32'(ack), 0);
        adr = 14'h0; #1 chk("rst_data", dat_r, 0);
        adr = 14'h4; #1 chk("rst_ctrl", dat_r, 0);
        adr = 14'h8; #1 chk("rst_status", dat_r, 0);
        adr = 14'hC; #1 chk("rst_clkdiv", dat_r, 0);
        @(negedge clk);
        rst = 0;

        wb_write(8'h04, 32'h5);
        chk("ena_on", 32'(adc_ena), 1);
        wb_read(8'h04, d);
        chk("ctrl_read", d, 32'h5);
        wb_read(8'h08, d);
        chk("no_start_status", d, 32'h0);
        wb_write(8'h04, 32'h0);
        wb_write(8'h0C, 32'hFFFF_FF3A);
        wb_read(8'h0C, d);
        chk("clkdiv_read", d, 32'h3A);
        wb_read(8'h20, d);
        chk("unmapped_read", d, 32'hDEAD_BEEF);

        @(negedge clk);
        adr = 14'h20; cyc = 1; stb = 1; we = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            chk("ack_alternate", 32'(ack), 32'(i % 2 == 0));
        end
        @(negedge clk);
        cyc = 0; stb = 0;

        run_conv(8'hA5, 8'd0, "a5");
        run_conv(8'h00, 8'd0, "code00");
        run_conv(8'hFF, 8'd0, "codeFF");
        run_conv(8'h37, 8'd5, "div5");
        for (int i = 0; i < 4; i++)
            run_conv(8'($urandom_range(0, 255)), 8'($urandom_range(0, 2)), "random");

        vin = 8'h5A;
        wb_write(8'h0C, 32'h0);
        wb_write(8'h08, 32'h2);
        wb_write(8'h04, 32'h3);
        t1 = t_commit;
        repeat (10) @(posedge clk);
        wb_write(8'h04, 32'h3);
        wait_done(t1, lat, bf, be);
        chk("busy_start_latency", lat, SAMPLE + 8 * 3 + 1);
        wb_write(8'h08, 32'h2);
        repeat (40) @(posedge clk);
        wb_read(8'h08, d);
        chk("busy_start_single_done", d, 32'h0);
        wb_read(8'h00, d);
        chk("busy_start_data", d, 32'h5A);

        vin = 8'hC3;
        wb_write(8'h04, 32'h3);
        t1 = t_commit;
        repeat (SAMPLE + 8 * 3) @(posedge clk);
        wb_write(8'h08, 32'h2);
        chk("w1c_commit_cycle", t_commit - t1, SAMPLE + 8 * 3 + 1);
        wb_read(8'h08, d);
        chk("w1c_set_wins", d, 32'h2);
        wb_read(8'h00, d);
        chk("w1c_data", d, 32'hC3);

        vin = 8'h10;
        wb_write(8'h08, 32'h2);
        wb_write(8'h04, 32'h7);
        wait_done(t_commit, lat, bf, be);
        chk("cont_latency1", lat, SAMPLE + 8 * 3 + 1);
        t1 = cyc_n;
        vin = 8'h3C;
        wb_read(8'h00, d);
        chk("cont_data1", d, 32'h10);
        wb_write(8'h08, 32'h2);
        wait_done(t1, lat, bf, be);
        chk("cont_period", lat, SAMPLE + 8 * 3 + 1);
        chk("cont_still_busy", 32'(be), 1);
        wb_read(8'h00, d);
        chk("cont_data2", d, 32'h3C);
        repeat (6) @(posedge clk);
        wb_write(8'h04, 32'h0);
        @(posedge clk); #1;
        chk("abort_sh_en", 32'(sh_en), 0);
        chk("abort_dac", 32'(dac), 0);
        chk("abort_adc_ena", 32'(adc_ena), 0);
        wb_read(8'h00, d);
        chk("abort_data_kept", d, 32'h3C);
        wb_read(8'h08, d);
        chk("abort_status", d, 32'h2);

        vin = 8'h77;
        wb_write(8'h08, 32'h2);
        wb_write(8'h04, 32'h3);
        repeat (12) @(posedge clk);
        #3;
        chk("pre_rst_dac_active", 32'(dac != 8'h00), 1);
        rst = 1;
        #1;
        chk("midrst_sh_en", 32'(sh_en), 0);
        chk("midrst_dac", 32'(dac), 0);
        chk("midrst_adc_ena", 32'(adc_ena), 0);
        chk("midrst_ack", 32'(ack), 0);
        adr = 14'h0; #1 chk("midrst_data", dat_r, 0);
        adr = 14'h4; #1 chk("midrst_ctrl", dat_r, 0);
        adr = 14'h8; #1 chk("midrst_status", dat_r, 0);
        @(negedge clk);
        rst = 0;
        run_conv(8'h77, 8'd0, "post_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
